// File: rtl/ibuf2bkd.sv
// ibuf2bkd: streams committed ibuf packets (descriptor + payload) to the backend as AXI4-Stream
// and returns consumed slots to the writer through committed_cons.
module ibuf2bkd #(
    parameter int BW = 10
) (
    input  logic          clk,
    input  logic          rst,
    output logic [BW-1:0] rd_addr,
    input  logic [63:0]   rd_data,
    input  logic [BW:0]   committed_prod,
    output logic [BW:0]   committed_cons,
    input  logic          bkd_rdy,
    output logic          activity,
    output logic [63:0]   m_axis_tdata,
    output logic [7:0]    m_axis_tstrb,
    output logic [127:0]  m_axis_tuser,
    output logic          m_axis_tvalid,
    output logic          m_axis_tlast,
    input  logic          m_axis_tready
);
    localparam int AW = BW + 1;

    typedef enum logic [2:0] {S_INIT, S_WAIT, S_IDLE, S_HDR, S_DESC, S_DATA, S_COMMIT} state_t;
    state_t state, state_nx;

    logic          rdy_s1, rdy_s2;
    logic [AW-1:0] rd_ptr;
    logic [12:0]   nw, issued, sent;
    logic [7:0]    strb_last;
    logic          data_v;
    logic [63:0]   fifo [2];
    logic          wp, rp;
    logic [1:0]    cnt;
    logic          pop, push, issue, room;
    logic [15:0]   d_len;
    logic [12:0]   d_nw;

    assign d_len = rd_data[47:32];
    assign d_nw  = 13'((17'(d_len) + 17'd7) >> 3);
    assign pop   = m_axis_tvalid & m_axis_tready;
    assign push  = data_v;
    // A read may only be issued if its data will still fit once it lands next cycle.
    assign room  = (cnt + 2'(data_v) - 2'(pop)) <= 2'd1;
    assign issue = (state == S_DESC) ? (d_len != 16'd0) : (state == S_DATA) && room && (issued != nw);

    assign rd_addr       = rd_ptr[BW-1:0];
    assign m_axis_tvalid = cnt != 2'd0;
    assign m_axis_tdata  = fifo[rp];
    assign m_axis_tlast  = m_axis_tvalid && (sent == nw - 13'd1);
    assign m_axis_tstrb  = !m_axis_tvalid ? 8'h00 : m_axis_tlast ? strb_last : 8'hFF;
    assign activity      = pop;

    always_comb begin
        state_nx = state;
        case (state)
            S_INIT:   state_nx = S_WAIT;
            S_WAIT:   state_nx = rdy_s2 ? S_IDLE : S_WAIT;
            S_IDLE:   state_nx = !rdy_s2 ? S_WAIT : (committed_prod != committed_cons) ? S_HDR : S_IDLE;
            S_HDR:    state_nx = S_DESC;
            S_DESC:   state_nx = (d_len == 16'd0) ? S_IDLE : S_DATA;
            S_DATA:   state_nx = (issued == nw) ? S_COMMIT : S_DATA;
            S_COMMIT: state_nx = (pop && m_axis_tlast) ? S_IDLE : S_COMMIT;
            default:  state_nx = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_INIT;
            rdy_s1         <= 1'b0;
            rdy_s2         <= 1'b0;
            rd_ptr         <= '0;
            committed_cons <= '0;
            nw             <= '0;
            issued         <= '0;
            sent           <= '0;
            strb_last      <= '0;
            m_axis_tuser   <= '0;
            data_v         <= 1'b0;
            fifo[0]        <= '0;
            fifo[1]        <= '0;
            wp             <= 1'b0;
            rp             <= 1'b0;
            cnt            <= '0;
        end else begin
            state  <= state_nx;
            rdy_s1 <= (state != S_INIT) && bkd_rdy;
            rdy_s2 <= (state != S_INIT) && rdy_s1;
            data_v <= issue;
            cnt    <= cnt + 2'(push) - 2'(pop);
            if (push) begin
                fifo[wp] <= rd_data;
                wp       <= ~wp;
            end
            if (pop) begin
                rp   <= ~rp;
                sent <= sent + 13'd1;
            end
            if (issue) rd_ptr <= rd_ptr + AW'(1);
            if (state == S_DATA && issue) issued <= issued + 13'd1;
            case (state)
                S_INIT: begin
                    rd_ptr         <= '0;
                    committed_cons <= '0;
                end
                S_IDLE: rd_ptr <= committed_cons;
                S_HDR:  rd_ptr <= committed_cons + AW'(1);
                S_DESC: begin
                    m_axis_tuser <= {96'd0, rd_data[23:16], rd_data[7:0], d_len};
                    nw           <= d_nw;
                    strb_last    <= (d_len[2:0] == 3'd0) ? 8'hFF : 8'hFF >> (4'd8 - {1'b0, d_len[2:0]});
                    issued       <= 13'(issue);
                    sent         <= '0;
                    if (d_len == 16'd0) committed_cons <= committed_cons + AW'(1);
                end
                S_COMMIT: if (pop && m_axis_tlast) committed_cons <= committed_cons + AW'(nw) + AW'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: doc/ibuf2bkd.md
# ibuf2bkd

Transmit-side counterpart of the backend receive path: reads host-written packets out of an internal dual-port packet buffer (ibuf) and streams them to the backend as AXI4-Stream. Each packet in ibuf is one descriptor word followed by its payload words. The block reads the packet and emits it with length and ports in tuser. It then advances a committed consumer pointer that returns the slots to the host-side writer.

## Interface
- BW, 10, ibuf address width; pointers carry one extra wrap bit (BW+1 bits).
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rd_addr  out  BW  ibuf read address, registered.
- rd_data  in  64  ibuf read data, valid exactly one clk after rd_addr changes (synchronous BRAM, latency 1).
- committed_prod  in  BW+1  writer pointer: slot after the last fully written packet.
- committed_cons  out  BW+1  consumer pointer: slot after the last fully transmitted packet.
- bkd_rdy  in  1  backend enable; asynchronous to the FSM, double-registered before use.
- activity  out  1  one-clk pulse per transferred beat, for LED/idle logic.
- m_axis_tdata  out  64  payload.
- m_axis_tstrb  out  8  byte enables; all-ones except on the last beat.
- m_axis_tuser  out  128  [15:0] len bytes, [23:16] src_port, [31:24] des_port, [127:32] zero; constant for the whole packet.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tlast  out  1  last beat of packet.
- m_axis_tready  in  1  backend accepts beat.

## Operation
- Descriptor word: [7:0] src_port, [23:16] des_port, [47:32] len (bytes); all other bits ignored. Payload occupies nw = (len+7)>>3 words starting at the descriptor address +1.
- Address arithmetic is modulo 2^(BW+1). rd_addr carries the low BW bits, so buffer wrap is implicit.
- Empty: committed_prod == committed_cons. The writer commits whole packets only, so a non-empty buffer guarantees the full packet is present.
- Last-beat tstrb: len[2:0]==0 gives 8'hFF; otherwise bits [len[2:0]-1:0] are set (e.g. len=61 gives 8'h1F).
- FSM states:
  - S_INIT: committed_cons<=0, rd ptr<=0, clear the bkd_rdy synchronizer; go to S_WAIT.
  - S_WAIT: hold until the synchronized bkd_rdy=1.
  - S_IDLE: when not empty, rd_addr<=committed_cons; go to S_HDR.
  - S_HDR: latency cycle. Set rd_addr<=descriptor+1.
  - S_DESC: latch len and ports into tuser; compute nw.
    - len==0: malformed. Skip it with committed_cons<=committed_cons+1 and return to S_IDLE.
    - Otherwise go to S_DATA.
  - S_DATA: stream nw words.
    - Fetch is pipelined through a 2-entry skid buffer, so that one beat per clk is sustained while tready=1.
    - rd_addr advances only when the skid buffer has room.
    - The beat count reaching nw asserts tlast.
  - S_COMMIT: on acceptance of the tlast beat (tvalid&tready&tlast), committed_cons<=descriptor+1+nw. Return to S_IDLE.
- AXIS rule: once tvalid=1, tdata, tstrb, tuser and tlast are held stable until tready=1.
- activity=1 in any clk with tvalid&tready, else 0.
- bkd_rdy deassertion mid-packet does not abort. The current packet completes, and the FSM stops in S_IDLE/S_WAIT before the next descriptor fetch.
- rst at any time: returns to S_INIT in the next clk. The in-flight packet is dropped without commit; its slots are re-sent only if the writer re-commits.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tstrb=0, m_axis_tuser=0, committed_cons=0, rd_addr=0, activity=0.
- Bring-up: first descriptor read no earlier than 3 clk after the raw bkd_rdy rises (synchronizer 2 + S_WAIT).
- Non-empty detection to first tvalid: 4 clk (S_IDLE addr, S_HDR, S_DESC, first data latency).
- Steady state with tready=1: 1 beat/clk, no bubbles within a packet.
- Inter-packet gap: at most 4 idle clk between the tlast beat and the next tvalid, when the next packet is already committed.
- committed_cons updates 1 clk after the tlast handshake.
- committed_prod is sampled in S_IDLE only. A change during S_DATA is picked up at the next S_IDLE.
- tready low for k clk stalls output exactly k clk. No beat is lost or duplicated; the skid buffer absorbs the in-flight read.

## Test plan
- Single packet, BW=10: descriptor len=64, src=1, des=2 at slot 0; 8 payload words; committed_prod=9.
  - Expect 8 beats with tuser[31:0]=32'h0201_0040 and last tstrb=8'hFF.
  - committed_cons=9 one clk after tlast.
- Odd length: len=61 → 8 beats, last tstrb=8'h1F, committed_cons advances by 9.
- Wrap: descriptor at slot 1020, len=48 (6 words), committed_prod=1027 (wrap bit set).
  - rd_addr sequence 1020,1021,1022,1023,0,1,2.
  - committed_cons=11'd1027.
- Backpressure: random tready (50%) over 20 back-to-back 1500-byte packets → output byte stream matches ibuf contents exactly; tdata stable while tvalid&!tready; no duplicate beats.
- len=0 descriptor followed by a valid packet → zero-length entry emits no beats and committed_cons advances by 1; the next packet is then sent normally.
- rst asserted mid-packet (beat 3 of 8) → tvalid=0 and committed_cons=0 next clk; nothing is transmitted until bkd_rdy has been re-synchronized.
